// File: rtl/fp64_pkg.sv
// Shared constants and the packed fp64 word layout for the Box-Muller datapath.
// Reduced IEEE-754 double: no NaN, Inf or denormals; the all-zero word is zero.
package fp64_pkg;

  localparam int FP_EXPW         = 11;
  localparam int FP_FRACW        = 52;
  localparam int FP_BIAS         = 1023;
  localparam logic [63:0] FP_ZERO = 64'h0;
  localparam int FP_FROM_INT_LAT = 4;

  typedef struct packed {
    logic                sign;
    logic [FP_EXPW-1:0]  exp;
    logic [FP_FRACW-1:0] frac;
  } fp64_t;

endpackage

// File: rtl/lzc_norm64.sv
// Combinational 64-bit leading-zero count and left-normalizer.
// A zero input yields norm=0 and lz=63; callers track zero separately.
module lzc_norm64 (
  input  logic [63:0] i_val,
  output logic [63:0] o_norm,
  output logic [5:0]  o_lz
);

  logic [63:0] w_v;
  logic [5:0]  w_lz;

  always_comb begin
    w_v  = i_val;
    w_lz = 6'd0;
    if (w_v[63:32] == 32'd0) begin
      w_lz[5] = 1'b1;
      w_v     = {w_v[31:0], 32'd0};
    end
    if (w_v[63:48] == 16'd0) begin
      w_lz[4] = 1'b1;
      w_v     = {w_v[47:0], 16'd0};
    end
    if (w_v[63:56] == 8'd0) begin
      w_lz[3] = 1'b1;
      w_v     = {w_v[55:0], 8'd0};
    end
    if (w_v[63:60] == 4'd0) begin
      w_lz[2] = 1'b1;
      w_v     = {w_v[59:0], 4'd0};
    end
    if (w_v[63:62] == 2'd0) begin
      w_lz[1] = 1'b1;
      w_v     = {w_v[61:0], 2'd0};
    end
    if (w_v[63] == 1'b0) begin
      w_lz[0] = 1'b1;
      w_v     = {w_v[62:0], 1'b0};
    end
  end

  assign o_norm = w_v;
  assign o_lz   = w_lz;

endmodule

// File: rtl/fp64_from_int.sv
// 4-stage 64-bit integer to fp64 converter (sign/mag, normalize, RNE round, pack).
// Define FP_FIX_SCALE_EN to treat the input as fixed point with FRAC fraction bits.
module fp64_from_int
  import fp64_pkg::*;
#(
  parameter int FRAC = 64,
  parameter int LAT  = FP_FROM_INT_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  input  logic        signed_in,
  input  logic [63:0] a,
  output logic        pushout,
  output logic [63:0] r
);

`ifdef FP_FIX_SCALE_EN
  localparam bit SCALE_EN = 1'b1;
`else
  localparam bit SCALE_EN = 1'b0;
`endif
  localparam logic [11:0] EXP_SCALE = SCALE_EN ? 12'(FRAC) : 12'd0;
  localparam logic [11:0] EXP_TOP   = 12'(FP_BIAS + 63);

  logic [LAT-1:0] r_vld;

  logic        r_s1_neg, r_s1_z;
  logic [63:0] r_s1_mag;

  logic        r_s2_neg, r_s2_z;
  logic [63:0] r_s2_norm;
  logic [5:0]  r_s2_lz;

  logic        r_s3_neg, r_s3_z, r_s3_c;
  logic [5:0]  r_s3_lz;
  logic [51:0] r_s3_frac;

  logic [63:0] r_out;

  logic        w_neg;
  logic [63:0] w_mag;
  logic [63:0] w_norm;
  logic [5:0]  w_lz;
  logic        w_rnd;
  logic [53:0] w_sum;
  logic [11:0] w_exp;
  fp64_t       w_pack;
  logic        w_unused_bits;

  assign w_neg = signed_in & a[63];
  assign w_mag = w_neg ? (~a + 64'd1) : a;

  lzc_norm64 u_lzc (
    .i_val  (r_s1_mag),
    .o_norm (w_norm),
    .o_lz   (w_lz)
  );

  // Ties go to the even mantissa; a carry out of bit 52 means the value became 2^(e+1).
  assign w_rnd = r_s2_norm[10] & ((|r_s2_norm[9:0]) | r_s2_norm[11]);
  assign w_sum = {1'b0, r_s2_norm[63:11]} + {53'd0, w_rnd};

  assign w_exp = EXP_TOP - {6'd0, r_s3_lz} + {11'd0, r_s3_c} - EXP_SCALE;

  always_comb begin
    w_pack      = '0;
    w_pack.sign = r_s3_neg;
    w_pack.exp  = w_exp[FP_EXPW-1:0];
    w_pack.frac = r_s3_frac;
  end

  assign w_unused_bits = w_sum[52] ^ w_exp[11];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld     <= '0;
      r_s1_neg  <= 1'b0;
      r_s1_z    <= 1'b0;
      r_s1_mag  <= 64'd0;
      r_s2_neg  <= 1'b0;
      r_s2_z    <= 1'b0;
      r_s2_norm <= 64'd0;
      r_s2_lz   <= 6'd0;
      r_s3_neg  <= 1'b0;
      r_s3_z    <= 1'b0;
      r_s3_c    <= 1'b0;
      r_s3_lz   <= 6'd0;
      r_s3_frac <= 52'd0;
      r_out     <= FP_ZERO;
    end else begin
      r_vld     <= {r_vld[LAT-2:0], pushin};

      r_s1_neg  <= w_neg;
      r_s1_z    <= (a == 64'd0);
      r_s1_mag  <= w_mag;

      r_s2_neg  <= r_s1_neg;
      r_s2_z    <= r_s1_z;
      r_s2_norm <= w_norm;
      r_s2_lz   <= w_lz;

      r_s3_neg  <= r_s2_neg;
      r_s3_z    <= r_s2_z;
      r_s3_c    <= w_sum[53];
      r_s3_lz   <= r_s2_lz;
      r_s3_frac <= w_sum[53] ? 52'd0 : w_sum[51:0];

      r_out     <= r_s3_z ? FP_ZERO : w_pack;
    end
  end

  assign pushout = r_vld[LAT-1];
  assign r       = r_out;

endmodule

// File: tb/tb_fp64_from_int.sv
// Scoreboard bench for fp64_from_int: directed boundary vectors, random stream, mid-flight reset.
// Expected words come from constants or an arithmetic round-to-nearest-even model.
module tb_fp64_from_int;

  logic        clk = 1'b0;
  logic        rst;
  logic        pushin;
  logic        signed_in;
  logic [63:0] a;
  logic        pushout;
  logic [63:0] r;

  fp64_from_int dut (
    .clk       (clk),
    .rst       (rst),
    .pushin    (pushin),
    .signed_in (signed_in),
    .a         (a),
    .pushout   (pushout),
    .r         (r)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit quiet    = 1'b0;

  logic [63:0] q_exp[$];
  logic [63:0] q_a[$];
  int          q_cyc[$];

`ifdef FP_FIX_SCALE_EN
  localparam int SCALE = 64;
`else
  localparam int SCALE = 0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_conv(input logic [63:0] av, input bit sg);
    logic        neg;
    logic [63:0] mag, m, rem, half;
    logic [11:0] e12;
    int p, q;
    neg = sg && av[63];
    mag = neg ? (64'd0 - av) : av;
    if (mag == 64'd0) return 64'd0;
    p = 63;
    while (p > 0 && !mag[p]) p--;
    if (p <= 52) begin
      m = mag << (52 - p);
    end else begin
      q    = p - 52;
      m    = mag >> q;
      rem  = mag & ((64'd1 << q) - 64'd1);
      half = 64'd1 << (q - 1);
      if (rem > half || (rem == half && m[0])) m = m + 64'd1;
      if (m == (64'd1 << 53)) begin
        m = m >> 1;
        p = p + 1;
      end
    end
    e12 = 12'(1023 + p - SCALE);
    return {neg, e12[10:0], m[51:0]};
  endfunction

  always @(negedge clk) begin
    logic [63:0] ev, av;
    int ic;
    if (rst) begin
      n_checks++;
      if (pushout !== 1'b0 || r !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_state pushout=%b r=%h required pushout=0 r=0", pushout, r);
      end
    end else begin
      if (quiet) begin
        n_checks++;
        if (pushout !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_quiet pushout=%b required 0", pushout);
        end
      end
      if (pushout === 1'b1) begin
        if (q_exp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pushout r=%h with no pending input", r);
        end else begin
          ev = q_exp.pop_front();
          av = q_a.pop_front();
          ic = q_cyc.pop_front();
          n_checks++;
          if (r !== ev) begin
            n_fail++;
            $display("FAIL result a=%h r=%h required %h", av, r, ev);
          end
          n_checks++;
          if (cyc - ic != 4) begin
            n_fail++;
            $display("FAIL latency a=%h got %0d cycles required 4", av, cyc - ic);
          end
        end
      end
    end
  end

  task automatic issue(input logic [63:0] av, input bit sg, input logic [63:0] ev);
    pushin    = 1'b1;
    a         = av;
    signed_in = sg;
    q_exp.push_back(ev);
    q_a.push_back(av);
    q_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    pushin = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int budget = 0;
    while (q_exp.size() != 0 && budget < 40) begin
      @(posedge clk);
      #1;
      budget++;
    end
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required 0", q_exp.size());
    end
  endtask

  initial begin
    logic [63:0] rv;
    bit          rs;
    rst       = 1'b1;
    pushin    = 1'b0;
    signed_in = 1'b0;
    a         = 64'd0;
    idle(3);
    rst = 1'b0;

`ifdef FP_FIX_SCALE_EN
    issue(64'h8000_0000_0000_0000, 1'b0, 64'h3FE0_0000_0000_0000);
    issue(64'h0000_0000_0000_0001, 1'b0, 64'h3BF0_0000_0000_0000);
    issue(64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h3FF0_0000_0000_0000);
`else
    issue(64'h0000_0000_0000_0001, 1'b0, 64'h3FF0_0000_0000_0000);
    idle(5);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hBFF0_0000_0000_0000);
    issue(64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000);
    issue(64'h0020_0000_0000_0001, 1'b0, 64'h4340_0000_0000_0000);
    issue(64'h0020_0000_0000_0003, 1'b0, 64'h4340_0000_0000_0002);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h43F0_0000_0000_0000);
    issue(64'h8000_0000_0000_0000, 1'b1, 64'hC3E0_0000_0000_0000);
    issue(64'h8000_0000_0000_0000, 1'b0, 64'h43E0_0000_0000_0000);
    issue(64'h001F_FFFF_FFFF_FFFF, 1'b0, 64'h433F_FFFF_FFFF_FFFF);
`endif
    drain();

    for (int i = 0; i < 100; i++) begin
      rv = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rv = rv >> $urandom_range(0, 63);
        1: rv = rv >> $urandom_range(8, 12);
        2: rv = (rv & 64'hFFFF_FFFF_FFFF_F800) | (64'd1 << 10);
        default: ;
      endcase
      rs = 1'($urandom_range(0, 1));
      issue(rv, rs, ref_conv(rv, rs));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    drain();

    pushin    = 1'b1;
    signed_in = 1'b0;
    a         = 64'd7;
    quiet     = 1'b1;
    idle(1);
    a = 64'd9;
    idle(1);
    a = 64'd11;
    idle(1);
    pushin = 1'b0;
    rst    = 1'b1;
    idle(2);
    rst = 1'b0;
    issue(64'd5, 1'b0, ref_conv(64'd5, 1'b0));
    idle(2);
    quiet = 1'b0;
`ifndef FP_FIX_SCALE_EN
    n_checks++;
    if (q_exp.size() != 1 || q_exp[0] !== 64'h4014_0000_0000_0000) begin
      n_fail++;
      $display("FAIL ref_model_five got %h required 4014000000000000", ref_conv(64'd5, 1'b0));
    end
`endif
    drain();
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
